load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the single-cycle datapath and a variable-latency data memory. It takes the datapath's address, store data and read/write strobes and runs a req/ack memory handshake. A one-entry posted store buffer lets stores retire without waiting for memory. It drives `Stall` so the core holds its PC and register writes until load data is ready or buffer space is free.

## Interface
Parameters:
- `ADDR_W`, 32: address width; bits [1:0] select the byte lane.
- `DATA_W`, 32: data width; fixed at 32, other values unsupported.

Ports (all outputs registered except `Stall` and `ReadData`):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `MemRead` in 1: the current instruction is a load.
- `MemWrite` in 1: the current instruction is a store.
- `ByteEn` in 1: byte access (LDRB/STRB); present only with `LSU_BYTE_EN`.
- `Addr` in ADDR_W: effective address (datapath `OPResult`).
- `WriteData` in 32: store data.
- `ReadData` out 32: load data to the result mux; 0 when not in RESP.
- `Stall` out 1: combinational; core must not advance while high.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: word address; bits [1:0] are always 0.
- `mem_wdata` out 32: write data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: transfer complete, sampled at the clock edge.
- `mem_rdata` in 32: read data, valid with `mem_ack` on reads.

## Operation
- FSM states: IDLE, STORE, LOAD, RESP.
- Store buffer holds `sb_valid`, `sb_addr`, `sb_data` and `sb_be`.
- **Store accept:** on `MemWrite && !Stall`, capture into the buffer at the edge and set `sb_valid`. The store retires from the core that cycle.
- **Store stall:** `Stall` = `MemWrite && sb_valid && !(state==STORE && mem_ack)`. A buffer draining this cycle frees the slot for a same-edge refill.
- **Drain:** IDLE with `sb_valid` → STORE, with `mem_req=1`, `mem_we=1` and buffer contents on the bus. On `mem_ack`:
  - clear `sb_valid` unless refilled that edge;
  - go to IDLE, or stay in STORE if refilled.
- **Load:** in IDLE with `MemRead` and `!sb_valid` → LOAD, with `mem_req=1`, `mem_we=0` and `mem_addr={Addr[31:2],2'b00}`. If the buffer is valid, drain first; stores always complete before a later load, and there is no forwarding.
- **Load completion:** in LOAD on `mem_ack`, register `mem_rdata` and go to RESP. In RESP, drive `ReadData`, hold `Stall=0`, and return to IDLE next cycle.
- **Load stall:** `Stall` = 1 whenever `MemRead` and state ≠ RESP.
- **Bus hold:** `mem_req` and the bus fields stay stable from assertion until the edge where `mem_ack` is sampled. `mem_req` deasserts the cycle after ack. No back-to-back requests without an idle cycle, except a STORE→STORE refill.
- **Illegal combination:** `MemRead && MemWrite` is never produced by the decoder. The LSU gives the read priority and drops the write, with no buffer capture.
- Word accesses ignore `Addr[1:0]` and use `mem_be=4'hF`.
- `mem_ack` outside STORE/LOAD is ignored.

## Timing
- Reset values: state IDLE, `sb_valid=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`, load register 0.
- Reset combinational outputs: `Stall=0` unless `MemRead` is high, `ReadData=0`.
- Reset mid-transaction drops `mem_req` immediately. The memory model discards the aborted transfer.
- Load with zero-wait memory (ack on the first LOAD cycle): `Stall` high for 2 cycles (IDLE, LOAD); data is committed at the end of cycle 3 (RESP).
- Each extra wait cycle adds one stall cycle.
- A store into an empty buffer costs 0 stall cycles.
- Memory write starts the cycle after capture and takes at least 1 cycle.

## Configuration
- `LSU_BYTE_EN` defined:
  - `ByteEn` port exists.
  - Byte store: `mem_be` is one-hot on `Addr[1:0]` (00→4'b0001 … 11→4'b1000), and `mem_wdata` = `WriteData[7:0]` replicated to all four lanes.
  - Byte load: `ReadData` = selected lane, zero-extended to 32 bits.
- `LSU_BYTE_EN` undefined:
  - No `ByteEn` port.
  - All accesses are word-wide with `mem_be=4'hF`.

## Structure
- Package `lsu_pkg` holds:
  - the state enum (IDLE/STORE/LOAD/RESP);
  - `BE_WORD=4'hF`;
  - the lane-select/replicate functions used by both store and load paths.
- Sub-module `lsu_store_buf`: the one-entry buffer, with inputs push/pop/data and outputs valid/contents. It handles same-edge push+pop.
- The FSM, bus drive and load-data path stay in `load_store_unit`.

## Test plan
- Store `Addr=0x100`, `WriteData=0xDEADBEEF`, mem ack after 3 cycles → `Stall` never high; one write with `mem_addr=0x100`, `mem_be=4'hF`, `mem_wdata=0xDEADBEEF`.
- Load `0x104`, zero-wait ack with `mem_rdata=0x12345678` → `Stall` high 2 cycles; `ReadData=0x12345678` in cycle 3; then IDLE.
- Store to `0x200` immediately followed by load from `0x200` → write completes before the read request; load stalls through the drain.
- Back-to-back stores with mem ack after 4 cycles → second store stalls until the first ack, then is accepted on that same edge.
- `LSU_BYTE_EN`: STRB `0xAB` to `0x103` → `mem_be=4'b1000`, `mem_wdata=0xABABABAB`. LDRB `0x101` with `mem_rdata=0x11223344` → `ReadData=0x00000033`.
- Assert `reset` during LOAD with `mem_req` high → `mem_req=0` the same cycle, state IDLE, `sb_valid=0`, `ReadData=0`.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Byte-lane functions serve both the store path and the load-data path.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [31:0] rep_byte(input logic [7:0] b);
    return {4{b}};
  endfunction

  function automatic logic [31:0] sel_lane(input logic [31:0] w, input logic [1:0] lane);
    return {24'h0, w[8*lane +: 8]};
  endfunction

endpackage

// File: rtl/load_store_unit_store_buf.sv
// One-entry posted store buffer; a push on the same edge as a pop
// keeps the entry valid with the new contents.
module lsu_store_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        be_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       data_o,
  output logic [3:0]        be_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (push_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      be_d    = be_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: posted store buffer plus req/ack memory FSM.
// Define LSU_BYTE_EN to add the ByteEn port and byte-lane stores/loads.
//
// state | meaning
// IDLE  | no bus transfer; drain buffer first, else start a load
// STORE | buffered write on the bus, waiting for mem_ack
// LOAD  | read on the bus, waiting for mem_ack
// RESP  | load data presented on ReadData, core released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
`ifdef LSU_BYTE_EN
  input  logic              ByteEn,
`endif
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, rdata_q;
  logic [3:0]        mem_be_q;

  logic              is_byte, ack_store, push;
  logic [ADDR_W-1:0] new_addr;
  logic [31:0]       new_data;
  logic [3:0]        new_be;
  logic              sb_valid;
  logic [ADDR_W-1:0] sb_addr;
  logic [31:0]       sb_data;
  logic [3:0]        sb_be;

`ifdef LSU_BYTE_EN
  assign is_byte = ByteEn;
`else
  assign is_byte = 1'b0;
`endif

  assign new_addr  = {Addr[ADDR_W-1:2], 2'b00};
  assign new_data  = is_byte ? rep_byte(WriteData[7:0]) : WriteData;
  assign new_be    = is_byte ? lane_be(Addr[1:0]) : BE_WORD;
  assign ack_store = (state_q == STORE) && mem_ack;

  // A draining entry frees the slot for a same-edge refill.
  assign Stall = (MemWrite && sb_valid && !ack_store) || (MemRead && state_q != RESP);
  assign push  = MemWrite && !MemRead && !Stall;

  lsu_store_buf #(.ADDR_W(ADDR_W)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (ack_store),
    .addr_i  (new_addr),
    .data_i  (new_data),
    .be_i    (new_be),
    .valid_o (sb_valid),
    .addr_o  (sb_addr),
    .data_o  (sb_data),
    .be_o    (sb_be)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sb_valid) begin
            state_q     <= STORE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= sb_addr;
            mem_wdata_q <= sb_data;
            mem_be_q    <= sb_be;
          end else if (MemRead) begin
            state_q    <= LOAD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= new_addr;
            mem_be_q   <= new_be;
          end
        end
        STORE: begin
          if (mem_ack) begin
            if (push) begin
              mem_addr_q  <= new_addr;
              mem_wdata_q <= new_data;
              mem_be_q    <= new_be;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
            end
          end
        end
        LOAD: begin
          // Core is stalled here, so Addr still names the loaded byte lane.
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            rdata_q   <= is_byte ? sel_lane(mem_rdata, Addr[1:0]) : mem_rdata;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign ReadData  = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; memory acks are
// driven step by step so each cycle's expected bus state is explicit.
module tb_load_store_unit;

  logic        clk, reset;
  logic        MemRead, MemWrite;
`ifdef LSU_BYTE_EN
  logic        ByteEn;
`endif
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
`ifdef LSU_BYTE_EN
    .ByteEn    (ByteEn),
`endif
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    mem_ack = 1'b0; mem_rdata = '0;
`ifdef LSU_BYTE_EN
    ByteEn = 1'b0;
`endif
    #12;
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_we",    {31'd0, mem_we},  32'd0);
    chk("rst_addr",  mem_addr,  32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be",    {28'd0, mem_be}, 32'd0);
    chk("rst_stall", {31'd0, Stall},  32'd0);
    chk("rst_rdata", ReadData,  32'd0);
    MemRead = 1'b1; #1;
    chk("rst_stall_rd", {31'd0, Stall}, 32'd1);
    MemRead = 1'b0;
    tick(); reset = 1'b0;
    tick();

    // Store 0x100 / DEADBEEF, ack on the 3rd bus cycle
    MemWrite = 1'b1; Addr = 32'h100; WriteData = 32'hDEADBEEF; #1;
    chk("st1_stall", {31'd0, Stall}, 32'd0);
    tick(); MemWrite = 1'b0; #1;
    chk("st1_noreq", {31'd0, mem_req}, 32'd0);
    tick(); #1;
    chk("st1_req",   {31'd0, mem_req}, 32'd1);
    chk("st1_we",    {31'd0, mem_we},  32'd1);
    chk("st1_addr",  mem_addr,  32'h100);
    chk("st1_be",    {28'd0, mem_be}, 32'hF);
    chk("st1_wdata", mem_wdata, 32'hDEADBEEF);
    tick(); #1;
    chk("st1_hold", {31'd0, mem_req}, 32'd1);
    tick(); mem_ack = 1'b1; #1;
    chk("st1_hold2", mem_addr, 32'h100);
    tick(); mem_ack = 1'b0; #1;
    chk("st1_reqoff", {31'd0, mem_req}, 32'd0);

    // Load 0x104, zero-wait ack
    MemRead = 1'b1; Addr = 32'h104; #1;
    chk("ld1_stall_c1", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("ld1_stall_c2", {31'd0, Stall}, 32'd1);
    chk("ld1_req",  {31'd0, mem_req}, 32'd1);
    chk("ld1_we",   {31'd0, mem_we},  32'd0);
    chk("ld1_addr", mem_addr, 32'h104);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("ld1_stall_c3", {31'd0, Stall}, 32'd0);
    chk("ld1_data", ReadData, 32'h12345678);
    chk("ld1_reqoff", {31'd0, mem_req}, 32'd0);
    tick(); MemRead = 1'b0; #1;
    chk("ld1_idle_data", ReadData, 32'd0);
    chk("ld1_idle_req", {31'd0, mem_req}, 32'd0);

    // Store 0x200 then load 0x200: drain first
    MemWrite = 1'b1; Addr = 32'h200; WriteData = 32'hCAFEF00D; #1;
    chk("st2_stall", {31'd0, Stall}, 32'd0);
    tick(); MemWrite = 1'b0; MemRead = 1'b1; #1;
    chk("sl_stall_a", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("sl_wr_req", {31'd0, mem_req}, 32'd1);
    chk("sl_wr_we",  {31'd0, mem_we},  32'd1);
    chk("sl_wr_addr", mem_addr, 32'h200);
    chk("sl_stall_b", {31'd0, Stall}, 32'd1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    chk("sl_gap_req", {31'd0, mem_req}, 32'd0);
    chk("sl_stall_c", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("sl_rd_req", {31'd0, mem_req}, 32'd1);
    chk("sl_rd_we",  {31'd0, mem_we},  32'd0);
    chk("sl_rd_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("sl_data", ReadData, 32'hCAFEF00D);
    chk("sl_stall_d", {31'd0, Stall}, 32'd0);
    tick(); MemRead = 1'b0;

    // Back-to-back stores, ack on the 4th bus cycle
    MemWrite = 1'b1; Addr = 32'h300; WriteData = 32'h11111111; #1;
    chk("bb_stall1", {31'd0, Stall}, 32'd0);
    tick(); Addr = 32'h304; WriteData = 32'h22222222; #1;
    chk("bb_stall2", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("bb_req1_addr", mem_addr, 32'h300);
    chk("bb_stall3", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("bb_stall4", {31'd0, Stall}, 32'd1);
    tick(); #1;
    chk("bb_hold_addr", mem_addr, 32'h300);
    tick(); mem_ack = 1'b1; #1;
    chk("bb_accept", {31'd0, Stall}, 32'd0);
    tick(); mem_ack = 1'b0; MemWrite = 1'b0; #1;
    chk("bb_req2", {31'd0, mem_req}, 32'd1);
    chk("bb_req2_addr", mem_addr, 32'h304);
    chk("bb_req2_data", mem_wdata, 32'h22222222);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; #1;
    chk("bb_reqoff", {31'd0, mem_req}, 32'd0);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_data", ReadData, 32'd0);

`ifdef LSU_BYTE_EN
    ByteEn = 1'b1; MemWrite = 1'b1; Addr = 32'h103; WriteData = 32'h000000AB;
    tick(); MemWrite = 1'b0;
    tick(); #1;
    chk("strb_addr", mem_addr, 32'h100);
    chk("strb_be", {28'd0, mem_be}, 32'h8);
    chk("strb_wdata", mem_wdata, 32'hABABABAB);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    MemRead = 1'b1; Addr = 32'h101;
    tick(); #1;
    chk("ldrb_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    tick(); mem_ack = 1'b0; mem_rdata = '0; #1;
    chk("ldrb_data", ReadData, 32'h00000033);
    tick(); MemRead = 1'b0; ByteEn = 1'b0;
`endif

    // Reset asserted mid-load
    MemRead = 1'b1; Addr = 32'h400;
    tick(); #1;
    chk("rl_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; #1;
    chk("rl_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rl_rdata", ReadData, 32'd0);
    MemRead = 1'b0; MemWrite = 1'b1; #1;
    chk("rl_sb_empty", {31'd0, Stall}, 32'd0);
    MemWrite = 1'b0;
    tick(); reset = 1'b0;
    tick(); #1;
    chk("rl_idle_req", {31'd0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
